// File: rtl/dvi_pkg.sv
// dvi_pkg: shared state/phase types and 720p default timing for the DVI timing controller
package dvi_pkg;
  typedef enum logic {IDLE, RUN} run_state_t;
  typedef enum logic [1:0] {ACTIVE, FP, SYNC, BP} phase_t;
  localparam int H_ACTIVE_720P = 1280;
  localparam int H_FP_720P = 110;
  localparam int H_SYNC_720P = 40;
  localparam int H_BP_720P = 220;
  localparam int V_ACTIVE_720P = 720;
  localparam int V_FP_720P = 5;
  localparam int V_SYNC_720P = 5;
  localparam int V_BP_720P = 20;
  localparam bit HS_POL_720P = 1'b1;
  localparam bit VS_POL_720P = 1'b1;
  localparam logic [23:0] FILL_RGB_720P = 24'h000000;
endpackage

// File: rtl/dvi_timing_ctrl_if.sv
// dvi_timing_ctrl_if: show-ahead pixel source handshake between frame source and timing controller
interface dvi_timing_ctrl_if;
  logic pix_req;
  logic pix_valid;
  logic [23:0] pix_rgb;
  modport master (output pix_req, input pix_valid, input pix_rgb);
  modport slave (input pix_req, output pix_valid, output pix_rgb);
endinterface

// File: rtl/dvi_phase_counter.sv
// dvi_phase_counter: wrapping counter split into ACTIVE/FP/SYNC/BP phases with a wrap strobe
module dvi_phase_counter
  import dvi_pkg::*;
#(
  parameter int W = 12,
  parameter int ACT = 1280,
  parameter int FP_LEN = 110,
  parameter int SYNC_LEN = 40,
  parameter int BP_LEN = 220
) (
  input  logic         pix_clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output phase_t       phase,
  output logic         wrap
);
  localparam int TOTAL = ACT + FP_LEN + SYNC_LEN + BP_LEN;
  localparam logic [W-1:0] LAST = W'(TOTAL - 1);
  localparam logic [W-1:0] FP_START = W'(ACT);
  localparam logic [W-1:0] SYNC_START = W'(ACT + FP_LEN);
  localparam logic [W-1:0] BP_START = W'(ACT + FP_LEN + SYNC_LEN);
  if (TOTAL > 2 ** W) begin : g_range_check
    $error("dvi_phase_counter: total %0d does not fit in %0d bits", TOTAL, W);
  end
  assign wrap = en && cnt == LAST;
  always_comb phase = cnt < FP_START ? ACTIVE : cnt < SYNC_START ? FP : cnt < BP_START ? SYNC : BP;
  always_ff @(posedge pix_clk)
    cnt <= (!rst_n || clr || wrap) ? '0 : en ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/dvi_timing_ctrl.sv
// dvi_timing_ctrl: raster timing, pixel fetch and registered TMDS encoder inputs
// Counters are decoded combinationally for pix_req; everything toward the encoders is one register later.
module dvi_timing_ctrl
  import dvi_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_720P,
  parameter int H_FP = H_FP_720P,
  parameter int H_SYNC = H_SYNC_720P,
  parameter int H_BP = H_BP_720P,
  parameter int V_ACTIVE = V_ACTIVE_720P,
  parameter int V_FP = V_FP_720P,
  parameter int V_SYNC = V_SYNC_720P,
  parameter int V_BP = V_BP_720P,
  parameter bit HS_POL = HS_POL_720P,
  parameter bit VS_POL = VS_POL_720P,
  parameter logic [23:0] FILL_RGB = FILL_RGB_720P
) (
  input  logic                 pix_clk,
  input  logic                 rst_n,
  input  logic                 enable,
  dvi_timing_ctrl_if.master    pix,
  input  logic                 underrun_clr,
  output logic                 de,
  output logic [1:0]           ctrl_b,
  output logic [1:0]           ctrl_g,
  output logic [1:0]           ctrl_r,
  output logic [7:0]           data_r,
  output logic [7:0]           data_g,
  output logic [7:0]           data_b,
  output logic [11:0]          x,
  output logic [10:0]          y,
  output logic                 frame_start,
  output logic                 underrun
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  if (H_TOTAL > 4096 || V_TOTAL > 2048) begin : g_size_check
    $error("dvi_timing_ctrl: raster %0dx%0d exceeds 4096x2048", H_TOTAL, V_TOTAL);
  end
  run_state_t state;
  logic [11:0] h;
  logic [10:0] v;
  phase_t h_ph, v_ph;
  logic h_wrap, v_wrap, run, active;
  assign run = state == RUN;
  assign active = run && h_ph == ACTIVE && v_ph == ACTIVE;
  assign pix.pix_req = active;
  assign ctrl_g = 2'b00;
  assign ctrl_r = 2'b00;
  dvi_phase_counter #(.W(12), .ACT(H_ACTIVE), .FP_LEN(H_FP), .SYNC_LEN(H_SYNC), .BP_LEN(H_BP)) u_h (
    .pix_clk(pix_clk), .rst_n(rst_n), .clr(!run), .en(run), .cnt(h), .phase(h_ph), .wrap(h_wrap)
  );
  // v only steps on h wrap, so vsync edges land on the h=0 boundary
  dvi_phase_counter #(.W(11), .ACT(V_ACTIVE), .FP_LEN(V_FP), .SYNC_LEN(V_SYNC), .BP_LEN(V_BP)) u_v (
    .pix_clk(pix_clk), .rst_n(rst_n), .clr(!run), .en(h_wrap), .cnt(v), .phase(v_ph), .wrap(v_wrap)
  );
  always_ff @(posedge pix_clk)
    if (!rst_n) begin
      state <= IDLE;
      de <= 1'b0;
      ctrl_b <= {~VS_POL, ~HS_POL};
      {data_r, data_g, data_b} <= '0;
      x <= '0;
      y <= '0;
      frame_start <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state <= !run ? (enable ? RUN : IDLE) : (v_wrap && !enable) ? IDLE : RUN;
      de <= active;
      ctrl_b <= {(run && v_ph == SYNC) ? VS_POL : ~VS_POL, (run && h_ph == SYNC) ? HS_POL : ~HS_POL};
      {data_r, data_g, data_b} <= active ? (pix.pix_valid ? pix.pix_rgb : FILL_RGB) : '0;
      x <= active ? h : '0;
      y <= active ? v : '0;
      frame_start <= active && h == '0 && v == '0;
      underrun <= (active && !pix.pix_valid) || (underrun && !underrun_clr);
    end
endmodule
